// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and burst sequencer for a shared 4:1 valid/ready data mux.
// The select {s1,s0} is registered and held for a whole burst, so bursts never interleave.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_last,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  s0,
    output logic                  s1,
    output logic [3:0]            grant,
    output logic                  busy
);

    // Handshake: a beat moves when out_valid && out_ready; in_ready[sel] mirrors
    // out_ready while a grant is held, so the source and consumer see the same beat.

    typedef enum logic [0:0] {IDLE, HOLD} state_t;

    state_t     state;
    logic [1:0] sel;
    logic [1:0] ptr;
    logic [7:0] cnt;

    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       beat;
    logic       release_now;
    logic [8:0] cnt_inc;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        pick  = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        out_data = '0;
        in_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (sel == 2'(i)) begin
                out_data = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = busy & out_ready;
            end
        end
    end

    assign out_valid   = busy & in_valid[sel];
    assign out_last    = busy & in_last[sel];
    assign beat        = out_valid & out_ready;
    assign cnt_inc     = {1'b0, cnt} + 9'd1;
    assign release_now = beat & (in_last[sel] | (cnt_inc == 9'(MAX_BURST)));

    assign s1 = sel[1];
    assign s0 = sel[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 8'd0;
            grant <= 4'b0000;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= HOLD;
                        sel   <= pick;
                        grant <= 4'b0001 << pick;
                        busy  <= 1'b1;
                        cnt   <= 8'd0;
                    end
                end
                HOLD: begin
                    // sel is left untouched on release so the mux select never glitches.
                    if (release_now) begin
                        state <= IDLE;
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                        ptr   <= sel + 2'd1;
                        cnt   <= 8'd0;
                    end else if (beat) begin
                        cnt <= cnt_inc[7:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (DATA_W=8, MAX_BURST=4).
module tb_mux4_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        s0;
    logic        s1;
    logic [3:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .s0(s0), .s1(s1), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        in_valid  = 4'b0000;
        in_last   = 4'b0000;
        in_data   = 32'h0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        in_data   = 32'h44332211;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if ({s1, s0} !== 2'b00) begin errors++; $display("FAIL rst_sel: got %b expected 00", {s1, s0}); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b expected 0000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", grant); end
        checks++; if ({s1, s0} !== 2'b00) begin errors++; $display("FAIL rst_first_sel: got %b expected 00", {s1, s0}); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        do_reset();
        in_data   = 32'h44332211;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_d = 8'h11 * 8'((k % 4) + 1);
            @(posedge clk);
            #1;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rot_grant[%0d]: got %b expected %b", k, grant, exp_g); end
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rot_data[%0d]: got %h expected %h", k, out_data, exp_d); end
            checks++; if (in_ready !== exp_g) begin errors++; $display("FAIL rot_in_ready[%0d]: got %b expected %b", k, in_ready, exp_g); end
            @(posedge clk);
            #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rot_gap[%0d]: got busy %b expected 0", k, busy); end
        end
    endtask

    task automatic test_burst_limit();
        do_reset();
        in_data   = 32'h005C0000;
        in_valid  = 4'b0100;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL lim_grant[%0d]: got %b expected 0100", i, grant); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lim_valid[%0d]: got %b expected 1", i, out_valid); end
        end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lim_release: got busy %b expected 0", busy); end
        checks++; if ({s1, s0} !== 2'b10) begin errors++; $display("FAIL lim_sel_hold: got %b expected 10", {s1, s0}); end
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL lim_regrant: got %b expected 0100", grant); end
        checks++; if ({s1, s0} !== 2'b10) begin errors++; $display("FAIL lim_regrant_sel: got %b expected 10", {s1, s0}); end
    endtask

    task automatic test_backpressure();
        logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] dat [5] = '{8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA3};
        logic       lst [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int beats;
        beats = 0;
        do_reset();
        in_valid  = 4'b0010;
        in_data   = 32'h0000A100;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            out_ready = rdy[i];
            in_data   = {16'h0, dat[i], 8'h0};
            in_last   = {2'b00, lst[i], 1'b0};
            #1;
            checks++; if (out_data !== dat[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, out_data, dat[i]); end
            checks++; if (in_ready !== {2'b00, rdy[i], 1'b0}) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, {2'b00, rdy[i], 1'b0}); end
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL bp_grant[%0d]: got %b expected 0010", i, grant); end
            if (out_valid && in_ready[1]) beats++;
            @(posedge clk);
            #1;
        end
        checks++; if (beats !== 3) begin errors++; $display("FAIL bp_beats: got %0d expected 3", beats); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release: got busy %b expected 0", busy); end
        in_valid = 4'b0000;
        in_last  = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        in_data   = 32'hD30000D0;
        in_valid  = 4'b1000;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL st_grant: got %b expected 1000", grant); end
        @(posedge clk);
        #1;
        in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL st_hold[%0d]: got %b expected 1000", i, grant); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL st_valid[%0d]: got %b expected 0", i, out_valid); end
            checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL st_ready0[%0d]: got %b expected 0", i, in_ready[0]); end
            @(posedge clk);
            #1;
        end
        in_valid = 4'b1001;
        in_last  = 4'b1000;
        #1;
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL st_last: got %b expected 1", out_last); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL st_release: got busy %b expected 0", busy); end
        in_valid = 4'b0001;
        in_last  = 4'b0000;
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL st_next: got %b expected 0001", grant); end
        in_valid = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_data   = 32'h0000B100;
        in_valid  = 4'b0010;
        in_last   = 4'b0010;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 in_last = 4'b0000;
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL ar_regrant: got %b expected 0010", grant); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL ar_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b expected 0", busy); end
        checks++; if ({s1, s0} !== 2'b00) begin errors++; $display("FAIL ar_sel: got %b expected 00", {s1, s0}); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL ar_in_ready: got %b expected 0000", in_ready); end
        in_valid = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ar_restart: got %b expected 0001", grant); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_data   = 32'h0;
        in_last   = 4'b0000;
        out_ready = 1'b0;
        test_reset();
        test_rotation();
        test_burst_limit();
        test_backpressure();
        test_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
